// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array tile controller: FSM states,
// drain-length arithmetic and the completed-tile counter width.
package sa_ctrl_pkg;

    localparam int TILES_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sa_state_t;

    // Cycles for the last operand to leave the buffer, cross the far corner PE and accumulate.
    function automatic int drain_len(input int hpe, input int vpe,
                                     input int mac_lat, input int rd_lat);
        return rd_lat + (hpe - 1) + (vpe - 1) + mac_lat;
    endfunction

endpackage

// File: rtl/sa_skew_chain.sv
// Tapped delay line producing a diagonal skew: lane n is the input delayed
// by n cycles, lane 0 is the input itself.
module sa_skew_chain #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         din,
    output logic [N-1:0] taps
);

    generate
        if (N == 1) begin : g_single
            assign taps = din;
        end else begin : g_chain
            logic [N-2:0] sr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else if (clr) begin
                    sr <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < N - 1; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign taps = {sr, din};
        end
    endgenerate

endmodule

// File: rtl/sa_tile_sequencer.sv
// Tile-level sequencer for the output-stationary systolic array: operand
// reads, edge skew enables, accumulator clear, drain wait and Y capture.
module sa_tile_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int HPE     = 16,
    parameter int VPE     = 16,
    parameter int KW      = 16,
    parameter int MAC_LAT = 1,
    parameter int RD_LAT  = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               rd_en,
    output logic [KW-1:0]      rd_addr,
    output logic [HPE-1:0]     row_en,
    output logic [VPE-1:0]     col_en,
    output logic               acc_clr,
    output logic               y_capture,
    output logic [TILES_W-1:0] tiles_done
);

    localparam int DRAIN_LEN = drain_len(HPE, VPE, MAC_LAT, RD_LAT);
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    generate
        if (RD_LAT != 1) begin : g_bad_rd_lat
            $error("sa_tile_sequencer supports RD_LAT == 1 only");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("sa_tile_sequencer requires WIDTH >= 1");
        end
    endgenerate

    sa_state_t            state_q, state_d;
    logic [KW-1:0]        k_q;
    logic [KW-1:0]        addr_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic [TILES_W-1:0]   tiles_q;
    logic                 feed_valid_q;
    logic                 skew_clr;

    assign busy       = (state_q != IDLE);
    assign rd_addr    = addr_q;
    assign tiles_done = tiles_q;
    assign skew_clr   = abort && (state_q != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over the normal sequence in every busy state; in DONE it also suppresses the result strobe.
    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        acc_clr   = 1'b0;
        done      = 1'b0;
        y_capture = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        state_d = FEED;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            FEED: begin
                rd_en   = 1'b1;
                acc_clr = (addr_q == '0);
                if (abort) begin
                    state_d = IDLE;
                end else if (addr_q == k_q - 1'b1) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (drain_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!abort) begin
                    done      = 1'b1;
                    y_capture = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start && (state_q != IDLE)) begin
            err = 1'b1;
        end
    end

    // Address counts only while FEED continues, so it sits at zero whenever no tile is feeding.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k_q          <= '0;
            addr_q       <= '0;
            drain_q      <= '0;
            tiles_q      <= '0;
            feed_valid_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start && k_len != '0) begin
                k_q <= k_len;
            end
            if (state_q == FEED && state_d == FEED) begin
                addr_q <= addr_q + 1'b1;
            end else begin
                addr_q <= '0;
            end
            if (state_q == FEED && state_d == DRAIN) begin
                drain_q <= DRAIN_W'(DRAIN_LEN - 1);
            end else if (state_q == DRAIN && drain_q != '0) begin
                drain_q <= drain_q - 1'b1;
            end
            if (state_q == DONE && !abort) begin
                tiles_q <= tiles_q + 1'b1;
            end
            feed_valid_q <= skew_clr ? 1'b0 : rd_en;
        end
    end

    sa_skew_chain #(.N(HPE)) u_row_skew (
        .clk  (CLK),
        .rst  (RST),
        .clr  (skew_clr),
        .din  (feed_valid_q),
        .taps (row_en)
    );

    sa_skew_chain #(.N(VPE)) u_col_skew (
        .clk  (CLK),
        .rst  (RST),
        .clr  (skew_clr),
        .din  (feed_valid_q),
        .taps (col_en)
    );

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Self-checking bench for sa_tile_sequencer on a 4x4 array (drain of 8 cycles)
// with a read-address scoreboard and a cycle-indexed expectation model.
module tb_sa_tile_sequencer;

    localparam int HPE = 4;
    localparam int VPE = 4;
    localparam int KW  = 16;
    localparam int D   = 8;
    localparam int NO_EVENT = 1000000;

    logic           CLK = 1'b0;
    logic           RST;
    logic           start;
    logic [KW-1:0]  k_len;
    logic           abort;
    logic           busy;
    logic           done;
    logic           err;
    logic           rd_en;
    logic [KW-1:0]  rd_addr;
    logic [HPE-1:0] row_en;
    logic [VPE-1:0] col_en;
    logic           acc_clr;
    logic           y_capture;
    logic [15:0]    tiles_done;

    int nTests = 0;
    int nFail  = 0;
    int expTiles = 0;
    int addrQ[$];

    sa_tile_sequencer #(
        .WIDTH   (32),
        .HPE     (HPE),
        .VPE     (VPE),
        .KW      (KW),
        .MAC_LAT (1),
        .RD_LAT  (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .k_len      (k_len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .row_en     (row_en),
        .col_en     (col_en),
        .acc_clr    (acc_clr),
        .y_capture  (y_capture),
        .tiles_done (tiles_done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [KW-1:0] k, input logic a);
        start = s;
        k_len = k;
        abort = a;
    endtask

    task automatic checkOutput(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic bit rdAt(input int t, input int k, input int a);
        return (t >= 1) && (t <= k) && (t <= a);
    endfunction

    // Runs one tile from the current cycle (t=0 carries the start) and checks every output cycle by cycle.
    task automatic runTile(input int k, input int abortAt, input int busyAt);
        int a;
        int tDone;
        int tEnd;
        int expAddr;
        logic [HPE-1:0] er;
        logic [VPE-1:0] ec;
        a     = (abortAt >= 1) ? abortAt : NO_EVENT;
        tDone = k + D + 1;
        tEnd  = ((a < tDone) ? a : tDone) + 1;
        for (int i = 0; i < k; i++) addrQ.push_back(i);
        for (int t = 0; t <= tEnd; t++) begin
            applyStimulus((t == 0) || (t == busyAt), KW'(k), (t == abortAt));
            #1;
            for (int i = 0; i < HPE; i++) er[i] = rdAt(t - 1 - i, k, a) && (t <= a);
            for (int j = 0; j < VPE; j++) ec[j] = rdAt(t - 1 - j, k, a) && (t <= a);
            checkOutput("busy", t, busy, (t >= 1) && (t <= tDone) && (t <= a));
            checkOutput("rd_en", t, rd_en, rdAt(t, k, a));
            checkOutput("acc_clr", t, acc_clr, (t == 1));
            checkOutput("row_en", t, row_en, er);
            checkOutput("col_en", t, col_en, ec);
            checkOutput("done", t, done, (t == tDone) && (a > tDone));
            checkOutput("y_capture", t, y_capture, (t == tDone) && (a > tDone));
            checkOutput("err", t, err, (t == busyAt) && (t >= 1) && (t <= tDone) && (t <= a));
            if (rd_en) begin
                if (addrQ.size() == 0) begin
                    checkOutput("rd_extra", t, 1, 0);
                end else begin
                    expAddr = addrQ.pop_front();
                    checkOutput("rd_addr", t, rd_addr, expAddr);
                end
            end
            if (t < tEnd) tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        if (a > tDone) begin
            expTiles = (expTiles + 1) % 65536;
            checkOutput("rd_count", tEnd, addrQ.size(), 0);
        end else begin
            addrQ.delete();
        end
        checkOutput("tiles_done", tEnd, tiles_done, expTiles);
    endtask

    initial begin
        RST = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        #12;
        checkOutput("rst_busy", 0, busy, 0);
        checkOutput("rst_rd_en", 0, rd_en, 0);
        checkOutput("rst_row_en", 0, row_en, 0);
        checkOutput("rst_tiles", 0, tiles_done, 0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // basic tile with a rejected start in cycle 5
        runTile(3, -1, 5);

        // zero-length request
        applyStimulus(1'b1, '0, 1'b0);
        #1;
        checkOutput("zero_err", 0, err, 1);
        checkOutput("zero_busy", 0, busy, 0);
        checkOutput("zero_rd_en", 0, rd_en, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("zero_busy_next", 1, busy, 0);
        checkOutput("zero_rd_en_next", 1, rd_en, 0);
        checkOutput("zero_err_next", 1, err, 0);
        tick();

        // aborts in DRAIN, FEED and DONE, then abort ignored alongside an IDLE start
        runTile(3, 6, -1);
        tick();
        runTile(5, 2, -1);
        tick();
        runTile(2, 2 + D + 1, -1);
        tick();
        runTile(2, 0, -1);
        tick();
        runTile(12, -1, -1);
        tick();

        // asynchronous reset in the middle of DRAIN
        applyStimulus(1'b1, KW'(3), 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        repeat (7) tick();
        checkOutput("pre_rst_busy", 8, busy, 1);
        #3;
        RST = 1'b1;
        #1;
        expTiles = 0;
        checkOutput("arst_busy", 8, busy, 0);
        checkOutput("arst_rd_en", 8, rd_en, 0);
        checkOutput("arst_row_en", 8, row_en, 0);
        checkOutput("arst_col_en", 8, col_en, 0);
        checkOutput("arst_done", 8, done, 0);
        checkOutput("arst_ycap", 8, y_capture, 0);
        checkOutput("arst_acc_clr", 8, acc_clr, 0);
        checkOutput("arst_err", 8, err, 0);
        checkOutput("arst_tiles", 8, tiles_done, 0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        runTile(1, -1, -1);
        tick();

        // counter wrap, then a start in the cycle right after DONE
        force dut.tiles_q = 16'hFFFF;
        #1;
        release dut.tiles_q;
        expTiles = 65535;
        checkOutput("preload_tiles", 0, tiles_done, 16'hFFFF);
        tick();
        runTile(2, -1, -1);
        runTile(1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
